gauss_window_ctrl: RTL and testbench

Sequencer and line-buffer controller that feeds the 3x3 Gaussian matrix stage. It takes a raster pixel stream, stores the two previous rows in on-chip line buffers and presents three vertically aligned row taps (din1/din2/din3) with a tap strobe. It also tracks row and column position, so it can flag when the downstream 3x3 window is fully inside the image and mark the end of a frame. It sits between the video source and the matrix stage.

---
 rtl/gauss_pkg.sv | 23 ++
 rtl/line_buffer.sv | 32 +++
 rtl/gauss_window_ctrl.sv | 133 +++++++++++++
 tb/tb_gauss_window_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared definitions for the Gaussian window controller and the 3x3 matrix stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gauss_pkg;

    // Sequencer states; encodings are shared with the matrix stage.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default pixel width: packed {R,G,B}, 8 bits each.
    localparam int DEF_WIDTH      = 24;
    localparam int DEF_PIC_WIDTH  = 480;
    localparam int DEF_PIC_HEIGHT = 272;

    // Column/row counter widths for the default picture size.
    localparam int COL_W = $clog2(DEF_PIC_WIDTH);
    localparam int ROW_W = $clog2(DEF_PIC_HEIGHT);

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line RAM holding one image row.
// Latency: one cycle from read enable to rd_dat; read-before-write on a shared address.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module line_buffer
    import gauss_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_PIC_WIDTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_dat,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Registered read returns the old word when a write hits the same address.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/gauss_window_ctrl.sv
// Line-buffer sequencer presenting three vertically aligned row taps to the 3x3 Gaussian stage.
// Latency: one cycle from accepted pixel to taps / tap_valid / win_valid; frame_done one cycle later.
// Backpressure: none; pix_valid=0 stalls counters and holds taps, one pixel per clock otherwise.
module gauss_window_ctrl
    import gauss_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [WIDTH-1:0] pix_data,
    input  logic             frame_start,
    output logic [WIDTH-1:0] din1_o,
    output logic [WIDTH-1:0] din2_o,
    output logic [WIDTH-1:0] din3_o,
    output logic             tap_valid,
    output logic             win_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(PIC_WIDTH);
    localparam int RW = $clog2(PIC_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    col, pos_col, pend_addr;
    logic [RW-1:0]    row, pos_row;
    logic             restart, acc, col_last, frame_last;
    logic             pend_vld, zero_din1, zero_din2;
    logic [WIDTH-1:0] lb0_rd_dat, lb1_rd_dat;

    // A frame_start pixel is always taken as (0,0); otherwise only FILL/RUN accept.
    assign restart    = pix_valid & frame_start;
    assign acc        = restart | (pix_valid & ((state == FILL) | (state == RUN)));
    assign pos_col    = restart ? '0 : col;
    assign pos_row    = restart ? '0 : row;
    assign col_last   = (pos_col == COL_LAST);
    assign frame_last = col_last & (pos_row == ROW_LAST);

    // Row r-1 comes straight from lb0; lb0 is refilled with the incoming pixel.
    line_buffer #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .ADDR_W(CW)) u_lb0 (
        .clk     (clk),
        .rd_en   (acc),
        .rd_addr (pos_col),
        .rd_dat  (lb0_rd_dat),
        .wr_en   (acc),
        .wr_addr (pos_col),
        .wr_dat  (pix_data)
    );

    // lb0's old word only appears one cycle after its read, so the cascade write into
    // lb1 lags by one accepted pixel. It lands on the previous column, which is never
    // the one being read, and always before that column is read again a row later.
    line_buffer #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .ADDR_W(CW)) u_lb1 (
        .clk     (clk),
        .rd_en   (acc),
        .rd_addr (pos_col),
        .rd_dat  (lb1_rd_dat),
        .wr_en   (acc & pend_vld),
        .wr_addr (pend_addr),
        .wr_dat  (lb0_rd_dat)
    );

    // Rows that do not exist yet are masked rather than clearing the RAMs.
    assign din1_o = zero_din1 ? '0 : lb1_rd_dat;
    assign din2_o = zero_din2 ? '0 : lb0_rd_dat;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a restart pixel overrides everything, including the last pixel.
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = FILL;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                FILL:    if (acc && col_last && (pos_row == RW'(1))) state_nxt = RUN;
                RUN:     if (acc && frame_last) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Raster position of the next pixel; advances only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            col <= col_last ? '0 : pos_col + 1'b1;
            row <= col_last ? ((pos_row == ROW_LAST) ? '0 : pos_row + 1'b1) : pos_row;
        end
    end

    // Tap registers, strobes, row masks and the deferred lb1 write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din3_o     <= '0;
            tap_valid  <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            zero_din1  <= 1'b1;
            zero_din2  <= 1'b1;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
        end else begin
            tap_valid  <= acc;
            win_valid  <= acc && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
            frame_done <= (state == DONE);
            if (acc) begin
                din3_o    <= pix_data;
                zero_din1 <= (pos_row < RW'(2));
                zero_din2 <= (pos_row == '0);
                pend_vld  <= 1'b1;
                pend_addr <= pos_col;
            end
        end
    end

endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Directed bench for gauss_window_ctrl on a 4x3 picture, pixel = base + row*16 + col.
// Latency: checks taps one edge after each accepted pixel, frame_done one edge later.
// Backpressure: exercises pix_valid gaps, restarts and asynchronous reset.
module tb_gauss_window_ctrl;

    localparam int WIDTH = 24;
    localparam int PW    = 4;
    localparam int PH    = 3;

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             pix_valid   = 1'b0;
    logic             frame_start = 1'b0;
    logic [WIDTH-1:0] pix_data    = '0;
    logic [WIDTH-1:0] din1_o, din2_o, din3_o;
    logic             tap_valid, win_valid, frame_done;

    int n_cmp  = 0;
    int n_bad  = 0;
    int fd_cnt = 0;
    int fd_exp = 0;

    gauss_window_ctrl #(
        .WIDTH      (WIDTH),
        .PIC_WIDTH  (PW),
        .PIC_HEIGHT (PH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .din1_o      (din1_o),
        .din2_o      (din2_o),
        .din3_o      (din3_o),
        .tap_valid   (tap_valid),
        .win_valid   (win_valid),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Count frame_done cycles away from the active edge.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input and land 1 time unit after the capturing edge.
    task automatic cyc(input logic v, input logic fs, input logic [WIDTH-1:0] d);
        pix_valid   = v;
        frame_start = fs;
        pix_data    = d;
        @(posedge clk);
        #1;
    endtask

    // Complete frame starting with frame_start, optionally with an idle cycle after each pixel.
    task automatic run_frame(input int base, input bit gapped);
        int wins;
        wins = 0;
        for (int r = 0; r < PH; r++) begin
            for (int c = 0; c < PW; c++) begin
                logic [WIDTH-1:0] d, e1, e2;
                d  = WIDTH'(base + r * 16 + c);
                e2 = (r >= 1) ? WIDTH'(base + (r - 1) * 16 + c) : '0;
                e1 = (r >= 2) ? WIDTH'(base + (r - 2) * 16 + c) : '0;
                cyc(1'b1, (r == 0 && c == 0), d);
                check_eq($sformatf("tap_valid r%0d c%0d", r, c), 32'(tap_valid), 32'd1);
                check_eq($sformatf("din3 r%0d c%0d", r, c), 32'(din3_o), 32'(d));
                check_eq($sformatf("din2 r%0d c%0d", r, c), 32'(din2_o), 32'(e2));
                check_eq($sformatf("din1 r%0d c%0d", r, c), 32'(din1_o), 32'(e1));
                check_eq($sformatf("win_valid r%0d c%0d", r, c), 32'(win_valid),
                         (r >= 2 && c >= 2) ? 32'd1 : 32'd0);
                check_eq($sformatf("frame_done r%0d c%0d", r, c), 32'(frame_done), 32'd0);
                if (win_valid) wins++;
                if (gapped && !(r == PH - 1 && c == PW - 1)) begin
                    cyc(1'b0, 1'b0, 24'hABCDEF);
                    check_eq($sformatf("gap tap_valid r%0d c%0d", r, c), 32'(tap_valid), 32'd0);
                    check_eq($sformatf("gap win_valid r%0d c%0d", r, c), 32'(win_valid), 32'd0);
                    check_eq($sformatf("gap din3 r%0d c%0d", r, c), 32'(din3_o), 32'(d));
                    check_eq($sformatf("gap din2 r%0d c%0d", r, c), 32'(din2_o), 32'(e2));
                    check_eq($sformatf("gap din1 r%0d c%0d", r, c), 32'(din1_o), 32'(e1));
                end
            end
        end
        cyc(1'b0, 1'b0, '0);
        check_eq("frame_done pulse", 32'(frame_done), 32'd1);
        check_eq("tap_valid after frame", 32'(tap_valid), 32'd0);
        cyc(1'b0, 1'b0, '0);
        check_eq("frame_done one cycle", 32'(frame_done), 32'd0);
        check_eq("win_valid count", 32'(wins), 32'd2);
        fd_exp++;
    endtask

    // First n pixels of a frame, only checking that each was accepted.
    task automatic partial(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, (i == 0), WIDTH'(base + (i / PW) * 16 + (i % PW)));
            check_eq($sformatf("partial tap_valid %0d", i), 32'(tap_valid), 32'd1);
        end
    endtask

    initial begin
        // Reset state.
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 24'h000055);
        check_eq("rst tap_valid", 32'(tap_valid), 32'd0);
        check_eq("rst win_valid", 32'(win_valid), 32'd0);
        check_eq("rst frame_done", 32'(frame_done), 32'd0);
        check_eq("rst din1", 32'(din1_o), 32'd0);
        check_eq("rst din2", 32'(din2_o), 32'd0);
        check_eq("rst din3", 32'(din3_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores pixels without frame_start.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, WIDTH'(32'h90 + i));
            check_eq("idle tap_valid", 32'(tap_valid), 32'd0);
            check_eq("idle din3", 32'(din3_o), 32'd0);
        end

        // Full frame with continuous valid, then the same with gaps and new data.
        run_frame(32'h000, 1'b0);
        run_frame(32'h100, 1'b1);
        check_eq("frame_done count a", 32'(fd_cnt), 32'(fd_exp));

        // Restart at (1,2): aborted frame gives no frame_done.
        partial(32'h200, 6);
        run_frame(32'h300, 1'b0);
        // Restart on the last-pixel slot: restart wins, no DONE.
        partial(32'h500, 11);
        run_frame(32'h600, 1'b0);
        check_eq("frame_done count b", 32'(fd_cnt), 32'(fd_exp));

        // Asynchronous reset while in RUN.
        partial(32'h700, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst tap_valid", 32'(tap_valid), 32'd0);
        check_eq("arst win_valid", 32'(win_valid), 32'd0);
        check_eq("arst frame_done", 32'(frame_done), 32'd0);
        check_eq("arst din1", 32'(din1_o), 32'd0);
        check_eq("arst din2", 32'(din2_o), 32'd0);
        check_eq("arst din3", 32'(din3_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, WIDTH'(32'h7A0 + i));
            check_eq("post-rst tap_valid", 32'(tap_valid), 32'd0);
            check_eq("post-rst din3", 32'(din3_o), 32'd0);
            check_eq("post-rst win_valid", 32'(win_valid), 32'd0);
        end
        run_frame(32'h800, 1'b0);
        cyc(1'b0, 1'b0, '0);
        check_eq("frame_done count c", 32'(fd_cnt), 32'(fd_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
